// File: rtl/permutator_pipe.sv
// Pipelined N-lane permutator: one register per butterfly stage, each stage applying
// an XOR-swap or a rotate on one bit of the beat's own cfg, with valid/ready backpressure.
module permutator_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOG2LANES  = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  flush,
    input  logic [(2**LOG2LANES)*DATA_WIDTH-1:0]  in_dat,
    input  logic [LOG2LANES-1:0]                  in_cfg,
    input  logic                                  in_mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [(2**LOG2LANES)*DATA_WIDTH-1:0]  out_dat,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [15:0]                           beat_cnt
);

    localparam int Lanes  = 2 ** LOG2LANES;
    localparam int Width  = Lanes * DATA_WIDTH;
    localparam int Stages = LOG2LANES;

    // Butterfly stage s: swap partner j^(2**s) or take lane (j + 2**s) mod N.
    function automatic logic [Width-1:0] butterfly(input logic [Width-1:0] d, input int s,
                                                   input logic en, input logic rot);
        logic [Width-1:0] r;
        int src;
        r = d;
        if (en) begin
            for (int j = 0; j < Lanes; j++) begin
                src = rot ? ((j + (1 << s)) & (Lanes - 1)) : (j ^ (1 << s));
                r[j*DATA_WIDTH +: DATA_WIDTH] = d[src*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    logic [Stages-1:0]    vld_q;
    logic [Width-1:0]     dat_q  [Stages];
    logic [Stages-1:0]    cfg_q  [Stages];
    logic                 mode_q [Stages];
    logic [15:0]          beat_cnt_q;

    logic [Stages-1:0]    adv;
    logic [Stages-1:0]    src_vld;
    logic [Width-1:0]     src_dat  [Stages];
    logic [Stages-1:0]    src_cfg  [Stages];
    logic                 src_mode [Stages];
    logic [Width-1:0]     nxt_dat  [Stages];

    // Advance chain runs from the output back toward stage 0.
    always_comb begin
        logic a;
        adv = '0;
        a   = !vld_q[Stages-1] || out_ready;
        adv[Stages-1] = a;
        for (int k = Stages - 2; k >= 0; k--) begin
            a      = !vld_q[k] || a;
            adv[k] = a;
        end
    end

    assign in_ready = adv[0] && !flush;

    always_comb begin
        src_vld     = '0;
        src_vld[0]  = in_valid && in_ready;
        src_dat[0]  = in_dat;
        src_cfg[0]  = in_cfg;
        src_mode[0] = in_mode;
        for (int s = 1; s < Stages; s++) begin
            src_vld[s]  = vld_q[s-1];
            src_dat[s]  = dat_q[s-1];
            src_cfg[s]  = cfg_q[s-1];
            src_mode[s] = mode_q[s-1];
        end
        for (int s = 0; s < Stages; s++) begin
            nxt_dat[s] = butterfly(src_dat[s], s, src_cfg[s][s], src_mode[s]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q      <= '0;
            beat_cnt_q <= '0;
            for (int s = 0; s < Stages; s++) begin
                dat_q[s]  <= '0;
                cfg_q[s]  <= '0;
                mode_q[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < Stages; s++) begin
                if (adv[s]) begin
                    vld_q[s]  <= src_vld[s];
                    dat_q[s]  <= nxt_dat[s];
                    cfg_q[s]  <= src_cfg[s];
                    mode_q[s] <= src_mode[s];
                end
            end
            // Flush wins over any load; the output handshake this cycle still counts.
            if (flush) begin
                vld_q <= '0;
            end
            if (out_valid && out_ready) begin
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid = vld_q[Stages-1];
    assign out_dat   = dat_q[Stages-1];
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_permutator_pipe.sv
// Directed self-checking bench for permutator_pipe at DATA_WIDTH=8, LOG2LANES=3.
module tb_permutator_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [63:0] in_dat;
    logic [2:0]  in_cfg;
    logic        in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_dat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    permutator_pipe #(
        .DATA_WIDTH (8),
        .LOG2LANES  (3)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_dat    (in_dat),
        .in_cfg    (in_cfg),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_dat   (out_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane j = {tag, index i_j}.
    function automatic logic [63:0] lanes(input logic [3:0] tag, input int i0, input int i1,
                                          input int i2, input int i3, input int i4,
                                          input int i5, input int i6, input int i7);
        int a [8];
        logic [63:0] r;
        a = '{i0, i1, i2, i3, i4, i5, i6, i7};
        for (int j = 0; j < 8; j++) r[j*8 +: 8] = {tag, 4'(a[j])};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [3:0] tag, input logic mode, input logic [2:0] cfg);
        in_dat   = lanes(tag, 0, 1, 2, 3, 4, 5, 6, 7);
        in_mode  = mode;
        in_cfg   = cfg;
        in_valid = 1'b1;
        #1;
    endtask

    task automatic run_single(input string tag, input logic [3:0] t, input logic mode,
                              input logic [2:0] cfg, input logic [63:0] exp,
                              input logic [15:0] exp_cnt);
        drive_beat(t, mode, cfg);
        step();
        in_valid = 1'b0;
        step();
        step();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_dat"}, out_dat, exp);
        step();
        check({tag, "_cnt"}, 64'(beat_cnt), 64'(exp_cnt));
    endtask

    logic [63:0] exp3 [8];
    logic [2:0]  cfg3 [8];
    logic [63:0] held;
    logic        rdy;
    logic        saw_valid;
    int          next_in;
    int          next_out;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_dat    = '0;
        in_cfg    = '0;
        in_mode   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("rst_out_dat", out_dat, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Single beats: XOR, rotate, identity in both modes.
        run_single("xor5", 4'h0, 1'b0, 3'd5, lanes(4'h0, 5, 4, 7, 6, 1, 0, 3, 2), 16'd1);
        run_single("rot3", 4'h1, 1'b1, 3'd3, lanes(4'h1, 3, 4, 5, 6, 7, 0, 1, 2), 16'd2);
        run_single("xor0", 4'h2, 1'b0, 3'd0, lanes(4'h2, 0, 1, 2, 3, 4, 5, 6, 7), 16'd3);
        run_single("rot0", 4'h3, 1'b1, 3'd0, lanes(4'h3, 0, 1, 2, 3, 4, 5, 6, 7), 16'd4);

        // Back-to-back beats, mode = beat[0], each with its own cfg.
        cfg3 = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd7, 3'd7, 3'd6, 3'd2};
        exp3[0] = lanes(4'h0, 1, 0, 3, 2, 5, 4, 7, 6);
        exp3[1] = lanes(4'h1, 1, 2, 3, 4, 5, 6, 7, 0);
        exp3[2] = lanes(4'h2, 2, 3, 0, 1, 6, 7, 4, 5);
        exp3[3] = lanes(4'h3, 5, 6, 7, 0, 1, 2, 3, 4);
        exp3[4] = lanes(4'h4, 7, 6, 5, 4, 3, 2, 1, 0);
        exp3[5] = lanes(4'h5, 7, 0, 1, 2, 3, 4, 5, 6);
        exp3[6] = lanes(4'h6, 6, 7, 4, 5, 2, 3, 0, 1);
        exp3[7] = lanes(4'h7, 2, 3, 4, 5, 6, 7, 0, 1);
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive_beat(4'(c), c[0], cfg3[c]);
                check($sformatf("b2b_in_ready%0d", c), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 2) begin
                check($sformatf("b2b_valid%0d", c - 2), 64'(out_valid), 64'd1);
                check($sformatf("b2b_dat%0d", c - 2), out_dat, exp3[c-2]);
            end
        end
        step();
        check("b2b_cnt", 64'(beat_cnt), 64'd12);
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Backpressure: only three beats fit while the output is blocked.
        out_ready = 1'b0;
        next_in   = 0;
        drive_beat(4'h1, 1'b0, 3'd0);
        for (int c = 0; c < 6; c++) begin
            rdy = in_ready;
            step();
            if (rdy && next_in < 5) begin
                next_in++;
                drive_beat(4'(1 + next_in), 1'b0, 3'd0);
            end
        end
        check("bp_accepted", 64'(next_in), 64'd3);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        held = out_dat;
        check("bp_head", held, lanes(4'h1, 0, 1, 2, 3, 4, 5, 6, 7));
        step();
        step();
        check("bp_stable", out_dat, lanes(4'h1, 0, 1, 2, 3, 4, 5, 6, 7));
        out_ready = 1'b1;
        #1;
        next_out = 0;
        for (int c = 0; c < 12 && next_out < 5; c++) begin
            rdy = in_ready;
            if (out_valid) begin
                check($sformatf("bp_out%0d", next_out), out_dat,
                      lanes(4'(1 + next_out), 0, 1, 2, 3, 4, 5, 6, 7));
                next_out++;
            end
            step();
            if (in_valid && rdy) begin
                next_in++;
                if (next_in < 5) drive_beat(4'(1 + next_in), 1'b0, 3'd0);
                else in_valid = 1'b0;
            end
        end
        check("bp_out_count", 64'(next_out), 64'd5);
        step();
        check("bp_cnt", 64'(beat_cnt), 64'd17);

        // Flush with three beats held and the output blocked.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_beat(4'(10 + k), 1'b0, 3'd0);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("fl_full", 64'(out_valid), 64'd1);
        drive_beat(4'hD, 1'b0, 3'd0);
        flush = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("fl_no_stale", 64'(saw_valid), 64'd0);
        check("fl_cnt", 64'(beat_cnt), 64'd17);

        // Flush coinciding with an output handshake: that beat still counts.
        drive_beat(4'hE, 1'b0, 3'd0);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("flhs_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flhs_out_valid", 64'(out_valid), 64'd0);
        check("flhs_cnt", 64'(beat_cnt), 64'd18);

        // Asynchronous reset mid-stream.
        drive_beat(4'hF, 1'b1, 3'd1);
        step();
        drive_beat(4'h0, 1'b1, 3'd2);
        step();
        in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_cnt", 64'(beat_cnt), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        #1;
        reset_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("mrst_no_output", 64'(saw_valid), 64'd0);

        // Counter wrap after 65536 handshakes.
        drive_beat(4'h0, 1'b0, 3'd0);
        for (int i = 0; i < 70000 && beat_cnt != 16'hFFFF; i++) step();
        check("wrap_reach_ffff", 64'(beat_cnt), 64'hFFFF);
        check("wrap_valid", 64'(out_valid), 64'd1);
        step();
        check("wrap_zero", 64'(beat_cnt), 64'd0);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
